// File: rtl/uart_rx_pkg.sv
// +----------------------------------------------------------------------+
// | uart_rx_pkg : shared state encoding, prescale constants, voter       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        OUT    = 3'd5
    } rx_state_e;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// +----------------------------------------------------------------------+
// | uart_rx_sampler : 2-of-3 majority vote around the bit centre         |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  sampled_bit
);

    logic [PRESCALE_W-1:0] w_half;
    logic [2:0]            samp_q;
    logic [2:0]            samp_d;

    assign w_half = Prescale >> 1;

    always_comb begin
        samp_d = samp_q;
        if (edge_cnt == w_half - 1'b1) samp_d[0] = RX_IN;
        if (edge_cnt == w_half)        samp_d[1] = RX_IN;
        if (edge_cnt == w_half + 1'b1) samp_d[2] = RX_IN;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) samp_q <= '0;
        else      samp_q <= samp_d;
    end

    // Settled from edge_cnt == Prescale/2+2 onward, well before the bit end.
    assign sampled_bit = maj3(samp_q);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// +----------------------------------------------------------------------+
// | uart_rx : oversampling UART receiver, optional parity check          |
// |           (enabled by defining PARITY_CHECK_EN)                      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
`ifdef PARITY_CHECK_EN
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`endif
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [PRESCALE_W-1:0] c_last_bit = PRESCALE_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [PRESCALE_W-1:0] bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  perr_q, perr_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;
    logic                  w_sampled;
    logic                  w_bit_end;
    logic                  w_par_en;
    logic                  w_par_typ;

`ifdef PARITY_CHECK_EN
    assign w_par_en  = PAR_EN;
    assign w_par_typ = PAR_TYP;
`else
    assign w_par_en  = 1'b0;
    assign w_par_typ = 1'b0;
`endif

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .edge_cnt    (edge_q),
        .Prescale    (Prescale),
        .sampled_bit (w_sampled)
    );

    assign w_bit_end = (edge_q == Prescale - 1'b1);

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pdata_d = pdata_q;
        perr_d  = perr_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;

        case (state_q)
            // The detect cycle itself is edge 0 of the start bit.
            IDLE, OUT: begin
                edge_d = '0;
                bit_d  = '0;
                perr_d = 1'b0;
                if (!RX_IN) begin
                    state_d = START;
                    edge_d  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = IDLE;
                end
            end
            START, DATA, PARITY, STOP: begin
                edge_d = w_bit_end ? '0 : edge_q + 1'b1;
                if (w_bit_end) begin
                    case (state_q)
                        START: state_d = w_sampled ? IDLE : DATA;
                        DATA: begin
                            shift_d = {w_sampled, shift_q[DATA_WIDTH-1:1]};
                            if (bit_q == c_last_bit) begin
                                bit_d   = '0;
                                state_d = w_par_en ? PARITY : STOP;
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end
                        PARITY: begin
                            perr_d  = (^shift_q) ^ w_par_typ ^ w_sampled;
                            state_d = STOP;
                        end
                        default: begin
                            // Outputs are registered here so they line up with OUT.
                            state_d = OUT;
                            pe_d    = perr_q;
                            se_d    = ~w_sampled;
                            dv_d    = w_sampled & ~perr_q;
                            if (w_sampled && !perr_q) pdata_d = shift_q;
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pdata_q <= '0;
            perr_q  <= 1'b0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            perr_q  <= perr_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +----------------------------------------------------------------------+
// | tb_uart_rx : directed self-checking bench for uart_rx                |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;
    import uart_rx_pkg::*;

`ifdef PARITY_CHECK_EN
    localparam bit c_par_build = 1'b1;
    logic PAR_EN  = 1'b0;
    logic PAR_TYP = 1'b0;
`else
    localparam bit c_par_build = 1'b0;
`endif

    logic       CLK      = 1'b0;
    logic       RST      = 1'b0;
    logic       RX_IN    = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int dv_cnt    = 0;
    int pe_cnt    = 0;
    int se_cnt    = 0;
    int pe_cyc    = 0;
    int se_cyc    = 0;
    int pdata_bad = 0;
    int dv_cyc[$];
    logic [7:0] dv_dat[$];
    logic [7:0] prev_pd = 8'h00;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    uart_rx #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
`ifdef PARITY_CHECK_EN
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
`endif
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cnt++;
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_DATA);
        end
        if (par_err) begin pe_cnt++; pe_cyc = cyc; end
        if (stp_err) begin se_cnt++; se_cyc = cyc; end
        if (RST && (P_DATA !== prev_pd) && !data_valid) pdata_bad++;
        prev_pd = P_DATA;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int ps, input bit pen);
        return (10 + ((pen && c_par_build) ? 1 : 0)) * ps;
    endfunction

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame starting at a negedge; returns the start-detect cycle.
    task automatic send_frame(input logic [7:0] d, input int ps, input bit pen,
                              input bit pbit, input bit sbit, output int t0);
        Prescale = 6'(ps);
`ifdef PARITY_CHECK_EN
        PAR_EN = pen;
`endif
        t0    = cyc;
        RX_IN = 1'b0;
        repeat (ps) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (ps) @(negedge CLK);
        end
        if (pen && c_par_build) begin
            RX_IN = pbit;
            repeat (ps) @(negedge CLK);
        end
        RX_IN = sbit;
        repeat (ps) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, base, k;

        repeat (3) @(negedge CLK);
        check("rst_pdata", P_DATA, 32'h0);
        check("rst_dv", data_valid, 32'h0);
        check("rst_perr", par_err, 32'h0);
        check("rst_serr", stp_err, 32'h0);
        RST = 1'b1;
        idle(4);

        // 0xA5, even parity bit 0 when parity is built in
        send_frame(8'hA5, PRESCALE_8, 1'b1, 1'b0, 1'b1, t0);
        idle(4);
        check("a5_count", dv_cnt, 32'd1);
        k = dv_cyc.size() - 1;
        if (k >= 0) begin
            check("a5_latency", dv_cyc[k] - t0, lat(8, 1'b1));
            check("a5_data", dv_dat[k], 32'hA5);
        end
        check("a5_perr", pe_cnt, 32'd0);
        check("a5_serr", se_cnt, 32'd0);

`ifdef PARITY_CHECK_EN
        send_frame(8'hA5, PRESCALE_8, 1'b1, 1'b1, 1'b1, t0);
        idle(4);
        check("par_bad_perr", pe_cnt, 32'd1);
        check("par_bad_lat", pe_cyc - t0, 32'd88);
        check("par_bad_dv", dv_cnt, 32'd1);
        check("par_bad_hold", P_DATA, 32'hA5);
`endif

        // Stop bit low at prescale 16
        base = dv_cnt;
        send_frame(8'h3C, PRESCALE_16, 1'b0, 1'b0, 1'b0, t0);
        idle(4);
        check("stp_count", se_cnt, 32'd1);
        check("stp_latency", se_cyc - t0, 32'd160);
        check("stp_no_dv", dv_cnt, base);
        check("stp_hold", P_DATA, 32'hA5);

        // Two-cycle glitch; a frame launched at cycle 8 must decode normally
        base     = dv_cnt;
        Prescale = 6'(PRESCALE_8);
        t0       = cyc;
        RX_IN    = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        check("glitch_at8", cyc - t0, 32'd8);
        send_frame(8'h96, PRESCALE_8, 1'b0, 1'b0, 1'b1, t1);
        idle(4);
        check("glitch_count", dv_cnt - base, 32'd1);
        k = dv_cyc.size() - 1;
        if (k >= 0) begin
            check("glitch_latency", dv_cyc[k] - t1, 32'd80);
            check("glitch_data", dv_dat[k], 32'h96);
        end
        check("glitch_errs", pe_cnt * 256 + se_cnt, (c_par_build ? 256 : 0) + 1);

        // Back-to-back frames at prescale 32
        base = dv_cnt;
        send_frame(8'h01, PRESCALE_32, 1'b0, 1'b0, 1'b1, t0);
        send_frame(8'hFF, PRESCALE_32, 1'b0, 1'b0, 1'b1, t1);
        idle(4);
        check("b2b_count", dv_cnt - base, 32'd2);
        if (dv_cyc.size() >= base + 2) begin
            check("b2b_lat1", dv_cyc[base] - t0, 32'd320);
            check("b2b_gap", dv_cyc[base+1] - dv_cyc[base], 32'd320);
            check("b2b_data1", dv_dat[base], 32'h01);
            check("b2b_data2", dv_dat[base+1], 32'hFF);
        end

        // Reset 40 cycles into a 0x55 frame
        base     = dv_cnt;
        Prescale = 6'(PRESCALE_8);
        RX_IN    = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = i[0] ? 1'b0 : 1'b1;
            repeat (8) @(negedge CLK);
        end
        RST = 1'b0;
        #1;
        check("mid_rst_pdata", P_DATA, 32'h0);
        check("mid_rst_flags", {data_valid, par_err, stp_err}, 32'h0);
        @(negedge CLK);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        idle(100);
        check("mid_rst_no_dv", dv_cnt, base);
        send_frame(8'h55, PRESCALE_8, 1'b0, 1'b0, 1'b1, t0);
        idle(4);
        check("post_rst_count", dv_cnt - base, 32'd1);
        k = dv_cyc.size() - 1;
        if (k >= 0) begin
            check("post_rst_lat", dv_cyc[k] - t0, 32'd80);
            check("post_rst_data", dv_dat[k], 32'h55);
        end

        check("pdata_stable", pdata_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, the number of payload bits per frame.
REQ-002 Parameter PRESCALE_W, default 6, the width of the prescale input.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  input  1  oversampling clock.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 RX_IN  input  1  serial line; idle high.
REQ-007 Prescale  input  PRESCALE_W  oversampling ratio; legal values are 8, 16 and 32; static during a frame.
REQ-008 PAR_EN  input  1  parity bit present (PARITY_CHECK_EN builds only).
REQ-009 PAR_TYP  input  1  parity type: 0 = even, 1 = odd (PARITY_CHECK_EN builds only).
REQ-010 P_DATA  output  DATA_WIDTH  received word, LSB first on the line.
REQ-011 data_valid  output  1  one-cycle pulse marking a good frame; this is the bus_enable source for the downstream data synchroniser.
REQ-012 par_err  output  1  one-cycle pulse on parity mismatch.
REQ-013 stp_err  output  1  one-cycle pulse when the stop bit samples 0.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and OUT.
- IDLE -> START on RX_IN==0; that cycle is edge_cnt 0 of the start bit.
REQ-015 An edge counter SHALL count 0..Prescale-1 within each bit period, and a bit counter SHALL count 0..DATA_WIDTH-1 in the DATA state.
REQ-016 Each bit value SHALL be the 2-of-3 majority of RX_IN sampled at edge_cnt Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-017 A start bit with a majority value of 1 SHALL be treated as a glitch: return to IDLE at the end of the bit, with no outputs.
REQ-018 DATA SHALL shift each sampled bit into the MSB of the shift register (LSB-first reception), so that after DATA_WIDTH bits bit 0 holds the first bit received.
REQ-019 The PARITY state SHALL be entered only when PAR_EN==1.
- Parity check: XOR of the data bits, XOR PAR_TYP, XOR the received parity bit; a mismatch latches the error.
REQ-020 STOP SHALL check the majority sample for 1.
REQ-021 OUT SHALL last one cycle, entered after edge_cnt==Prescale-1 of the stop bit.
- No error: pulse data_valid and load P_DATA.
- Parity error: pulse par_err only.
- Stop error: pulse stp_err only.
- Both errors: pulse both; data_valid stays low.
REQ-022 OUT SHALL go to START if RX_IN==0 in that cycle (back-to-back frames), otherwise to IDLE.
REQ-023 P_DATA SHALL hold its value until the next good frame; it changes only in the cycle data_valid is high.
REQ-024 Latency SHALL be (1+DATA_WIDTH+PAR_EN+1)*Prescale cycles from the start-detect cycle to data_valid.
- Prescale 8 with parity: 88 cycles.
REQ-025 The counters SHALL be PRESCALE_W bits wide; edge_cnt wraps to 0 at Prescale-1.

Reset
REQ-026 RST low SHALL force, asynchronously, the state to IDLE, all counters to 0, P_DATA to 0, and data_valid, par_err and stp_err to 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no output pulse; after release, reception restarts on the next falling edge of RX_IN.

Configuration
REQ-028 With PARITY_CHECK_EN defined, the block SHALL provide the PAR_EN and PAR_TYP ports, the PARITY state and par_err, as specified above.
REQ-029 Without PARITY_CHECK_EN, the block SHALL omit PAR_EN and PAR_TYP, use the fixed frame start + DATA_WIDTH + stop, and tie par_err to 0.

Structure
REQ-030 Package uart_rx_pkg SHALL hold the state enum typedef and the constants PRESCALE_8, PRESCALE_16 and PRESCALE_32.
REQ-031 Sub-module uart_rx_sampler SHALL contain the three-sample majority voter.
- Inputs: CLK, RST, RX_IN, edge_cnt, Prescale.
- Output: sampled_bit, valid at edge_cnt Prescale/2+2.

Verification
REQ-032 Prescale 8, PAR_EN 1, PAR_TYP 0, frame 0xA5 with even parity bit 0 -> P_DATA=0xA5, one-cycle data_valid 88 cycles after start detect, no errors.
REQ-033 Same setup with the parity bit flipped to 1 -> par_err for one cycle, data_valid stays 0, P_DATA keeps its previous value.
REQ-034 Prescale 16, PAR_EN 0, frame 0x3C with stop bit 0 -> stp_err at cycle 160, no data_valid.
REQ-035 Prescale 8, RX_IN low for 2 cycles then high -> no pulses, FSM back in IDLE by cycle 8.
REQ-036 Prescale 32, back-to-back frames 0x01 and 0xFF with no idle gap -> two data_valid pulses 320 cycles apart (PAR_EN 0), and P_DATA reads 0x01 then 0xFF.
REQ-037 RST asserted at cycle 40 of a frame -> all outputs 0 immediately; the following clean frame 0x55 is received correctly.
